// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GNT_I  = 3'd1,
    ST_GNT_D  = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } arb_state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_e;

  // Bits needed to hold any value 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Grant-state watchdog: counts unacknowledged cycles and keeps a sticky error.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_clr,
  input  logic cnt_en,
  input  logic err_clr,
  output logic timeout,
  output logic err
);

  localparam int unsigned WW = cnt_width(TIMEOUT);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_q, err_d;

  always_comb begin
    timeout  = (wd_cnt_q == WW'(TIMEOUT));
    wd_cnt_d = wd_cnt_q;
    if (cnt_clr) begin
      wd_cnt_d = '0;
    end else if (cnt_en && !timeout) begin
      wd_cnt_d = wd_cnt_q + WW'(1);
    end
    // A new timeout takes priority over a clear request in the same cycle.
    err_d = err_q;
    if (cnt_en && timeout) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-memory sides onto one req/ack memory port,
// with an I-side starvation guard and an abort watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err,
  input  logic          err_clr
);

  localparam int unsigned SW = cnt_width(STARVE_MAX);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          wd_clr, wd_en, wd_timeout;
  arb_side_e     gnt_side;
  logic          i_starved;

  assign i_starved = (starve_q >= SW'(STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    gnt_side    = (state_q == ST_GNT_D) ? SIDE_D : SIDE_I;

    case (state_q)
      ST_IDLE: begin
        if (d_req && (!i_req || !i_starved)) begin
          state_d     = ST_GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          wd_clr      = 1'b1;
          if (i_req && !i_starved) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (i_req) begin
          state_d    = ST_GNT_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          wd_clr     = 1'b1;
          starve_d   = '0;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        wd_en = !mem_ack;
        // An ack in the timeout cycle still completes with real data.
        if (mem_ack || wd_timeout) begin
          mem_req_d = 1'b0;
          if (gnt_side == SIDE_I) begin
            state_d   = ST_RESP_I;
            i_done_d  = 1'b1;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            state_d   = ST_RESP_D;
            d_done_d  = 1'b1;
            d_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          end
        end
      end
      ST_RESP_I, ST_RESP_D: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase

    if (!i_req) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .cnt_clr (wd_clr),
    .cnt_en  (wd_en),
    .err_clr (err_clr),
    .timeout (wd_timeout),
    .err     (err)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule
